// File: rtl/adxl362_sequencer.sv
// rtl/adxl362_sequencer.sv - ADXL362 bring-up and data-ready driven XYZ sample sequencer.
// Frames SPI transactions on a single-byte SPI engine and publishes the latest sample.
module adxl362_sequencer #(
    parameter logic [7:0] FILTER_CFG  = 8'h13,
    parameter logic [7:0] INTMAP1_CFG = 8'h01,
    parameter int         CS_GAP      = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        int1_i,
    output logic        spi_start_o,
    output logic [7:0]  spi_data_o,
    input  logic [7:0]  spi_data_i,
    input  logic        spi_done_i,
    output logic        ncs_o,
    output logic [15:0] x_o,
    output logic [15:0] y_o,
    output logic [15:0] z_o,
    output logic        sample_valid_o,
    output logic        ready_o,
    output logic        id_error_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_ID_RD,
        S_CFG_FILT,
        S_CFG_INT,
        S_CFG_PWR,
        S_WAIT_INT,
        S_DATA_RD,
        S_GAP,
        S_ERROR
    } state_t;

    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

    state_t      r_state;
    state_t      r_ret;
    state_t      w_next;
    state_t      w_ret_next;

    logic [2:0]  r_cnt;
    logic        r_busy;
    logic        r_launch;
    logic [7:0]  r_gap;
    logic        r_ncs;
    logic        r_start;
    logic [7:0]  r_data;
    logic [2:0]  r_int_sync;
    logic        r_int_pending;
    logic [7:0]  r_xl;
    logic [7:0]  r_xh;
    logic [7:0]  r_yl;
    logic [7:0]  r_yh;
    logic [7:0]  r_zl;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] r_z;
    logic        r_valid;
    logic        r_ready;
    logic        r_id_err;

    logic [2:0]  w_last_idx;
    logic        w_byte_done;
    logic        w_last_done;
    logic        w_id_ok;
    logic        w_gap_done;
    logic        w_int_rise;
    logic        w_enter_txn;

    function automatic logic is_txn(input state_t s);
        case (s)
            S_ID_RD, S_CFG_FILT, S_CFG_INT, S_CFG_PWR, S_DATA_RD: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] tx_byte(input state_t s, input logic [2:0] idx);
        case (s)
            S_ID_RD:    return (idx == 3'd0) ? 8'h0B : 8'h00;
            S_CFG_FILT: return (idx == 3'd0) ? 8'h0A : (idx == 3'd1) ? 8'h2C : FILTER_CFG;
            S_CFG_INT:  return (idx == 3'd0) ? 8'h0A : (idx == 3'd1) ? 8'h2A : INTMAP1_CFG;
            S_CFG_PWR:  return (idx == 3'd0) ? 8'h0A : (idx == 3'd1) ? 8'h2D : 8'h02;
            S_DATA_RD:  return (idx == 3'd0) ? 8'h0B : (idx == 3'd1) ? 8'h0E : 8'h00;
            default:    return 8'h00;
        endcase
    endfunction

    assign w_last_idx  = (r_state == S_DATA_RD) ? 3'd7 : 3'd2;
    assign w_byte_done = r_busy & spi_done_i;
    assign w_last_done = w_byte_done & (r_cnt == w_last_idx);
    assign w_id_ok     = (spi_data_i == 8'hAD);
    assign w_gap_done  = (r_state == S_GAP) && (r_gap == GAP_LAST);
    assign w_int_rise  = r_int_sync[1] & ~r_int_sync[2];
    assign w_enter_txn = (w_next != r_state) && is_txn(w_next);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_ret   <= S_IDLE;
        end else begin
            r_state <= w_next;
            r_ret   <= w_ret_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_ret_next = r_ret;
        case (r_state)
            S_IDLE: begin
                if (enable_i) w_next = S_ID_RD;
            end
            S_ID_RD: begin
                if (w_last_done) begin
                    w_next     = w_id_ok ? S_GAP : S_ERROR;
                    w_ret_next = S_CFG_FILT;
                end
            end
            S_CFG_FILT: begin
                if (w_last_done) begin
                    w_next     = S_GAP;
                    w_ret_next = S_CFG_INT;
                end
            end
            S_CFG_INT: begin
                if (w_last_done) begin
                    w_next     = S_GAP;
                    w_ret_next = S_CFG_PWR;
                end
            end
            S_CFG_PWR, S_DATA_RD: begin
                if (w_last_done) begin
                    w_next     = S_GAP;
                    w_ret_next = S_WAIT_INT;
                end
            end
            S_GAP: begin
                if (w_gap_done) w_next = enable_i ? r_ret : S_IDLE;
            end
            S_WAIT_INT: begin
                if (!enable_i)          w_next = S_IDLE;
                else if (r_int_pending) w_next = S_DATA_RD;
            end
            S_ERROR: begin
                if (!enable_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt         <= 3'd0;
            r_busy        <= 1'b0;
            r_launch      <= 1'b0;
            r_gap         <= 8'd0;
            r_ncs         <= 1'b1;
            r_start       <= 1'b0;
            r_data        <= 8'h00;
            r_int_sync    <= 3'b000;
            r_int_pending <= 1'b0;
            r_xl          <= 8'h00;
            r_xh          <= 8'h00;
            r_yl          <= 8'h00;
            r_yh          <= 8'h00;
            r_zl          <= 8'h00;
            r_x           <= 16'h0000;
            r_y           <= 16'h0000;
            r_z           <= 16'h0000;
            r_valid       <= 1'b0;
            r_ready       <= 1'b0;
            r_id_err      <= 1'b0;
        end else begin
            r_start    <= 1'b0;
            r_valid    <= 1'b0;
            r_int_sync <= {r_int_sync[1:0], int1_i};
            r_gap      <= (r_state == S_GAP) ? r_gap + 8'd1 : 8'd0;

            // A fresh edge wins over the clear so a coinciding request is never dropped.
            if (w_int_rise)
                r_int_pending <= 1'b1;
            else if (r_state == S_WAIT_INT && w_next == S_DATA_RD)
                r_int_pending <= 1'b0;

            if (w_enter_txn) begin
                r_ncs    <= 1'b0;
                r_launch <= 1'b1;
                r_cnt    <= 3'd0;
            end

            if (r_launch) begin
                r_launch <= 1'b0;
                r_start  <= 1'b1;
                r_data   <= tx_byte(r_state, 3'd0);
                r_busy   <= 1'b1;
            end

            if (w_byte_done) begin
                if (w_last_done) begin
                    r_busy <= 1'b0;
                    r_cnt  <= 3'd0;
                    r_ncs  <= 1'b1;
                end else begin
                    r_cnt   <= r_cnt + 3'd1;
                    r_start <= 1'b1;
                    r_data  <= tx_byte(r_state, r_cnt + 3'd1);
                end
                if (r_state == S_DATA_RD) begin
                    case (r_cnt)
                        3'd2: r_xl <= spi_data_i;
                        3'd3: r_xh <= spi_data_i;
                        3'd4: r_yl <= spi_data_i;
                        3'd5: r_yh <= spi_data_i;
                        3'd6: r_zl <= spi_data_i;
                        3'd7: begin
                            r_x     <= {r_xh, r_xl};
                            r_y     <= {r_yh, r_yl};
                            r_z     <= {spi_data_i, r_zl};
                            r_valid <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            if (r_state == S_CFG_PWR && w_last_done)
                r_ready <= 1'b1;
            if (r_state == S_ID_RD && w_last_done && !w_id_ok)
                r_id_err <= 1'b1;
            if (r_state != S_IDLE && w_next == S_IDLE) begin
                r_ready  <= 1'b0;
                r_id_err <= 1'b0;
            end
        end
    end

    assign spi_start_o    = r_start;
    assign spi_data_o     = r_data;
    assign ncs_o          = r_ncs;
    assign x_o            = r_x;
    assign y_o            = r_y;
    assign z_o            = r_z;
    assign sample_valid_o = r_valid;
    assign ready_o        = r_ready;
    assign id_error_o     = r_id_err;

endmodule

// File: tb/tb_adxl362_sequencer.sv
// tb/tb_adxl362_sequencer.sv - scoreboard bench for adxl362_sequencer with a byte-level sensor model.
module tb_adxl362_sequencer;

    localparam int CS_GAP = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic        int1_i;
    logic        spi_start_o;
    logic [7:0]  spi_data_o;
    logic [7:0]  spi_data_i;
    logic        spi_done_i;
    logic        ncs_o;
    logic [15:0] x_o;
    logic [15:0] y_o;
    logic [15:0] z_o;
    logic        sample_valid_o;
    logic        ready_o;
    logic        id_error_o;

    adxl362_sequencer #(
        .FILTER_CFG  (8'h13),
        .INTMAP1_CFG (8'h01),
        .CS_GAP      (CS_GAP)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .int1_i         (int1_i),
        .spi_start_o    (spi_start_o),
        .spi_data_o     (spi_data_o),
        .spi_data_i     (spi_data_i),
        .spi_done_i     (spi_done_i),
        .ncs_o          (ncs_o),
        .x_o            (x_o),
        .y_o            (y_o),
        .z_o            (z_o),
        .sample_valid_o (sample_valid_o),
        .ready_o        (ready_o),
        .id_error_o     (id_error_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          len;
        logic [63:0] b;
    } frame_t;

    frame_t      exp_frames[$];
    logic [47:0] exp_samples[$];
    int          tests = 0;
    int          fails = 0;

    logic [7:0]  mem [0:255];
    int          cur_len = 0;
    int          frames_done = 0;
    int          n_starts = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input int n, input logic [63:0] b);
        frame_t f;
        f.len = n;
        f.b   = b;
        exp_frames.push_back(f);
    endtask

    task automatic pulse_int();
        int1_i = 1'b1;
        repeat (3) @(posedge clk);
        int1_i = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    // Sensor model: answers each launched byte two cycles later.
    initial begin
        int         m_idx;
        logic [7:0] m_cmd;
        logic [7:0] m_addr;
        logic [7:0] b;
        logic [7:0] resp;
        logic [7:0] a;
        m_idx = 0;
        m_cmd = 8'h00;
        m_addr = 8'h00;
        spi_done_i = 1'b0;
        spi_data_i = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            spi_done_i = 1'b0;
            if (ncs_o === 1'b1) m_idx = 0;
            if (spi_start_o === 1'b1) begin
                b    = spi_data_o;
                resp = 8'h00;
                if (m_idx == 0) m_cmd = b;
                else if (m_idx == 1) m_addr = b;
                else begin
                    a = m_addr + 8'(m_idx - 2);
                    if (m_cmd == 8'h0B) resp = mem[a];
                    else if (m_cmd == 8'h0A) mem[a] = b;
                end
                m_idx++;
                repeat (2) @(posedge clk);
                #1;
                spi_done_i = 1'b1;
                spi_data_i = resp;
            end
        end
    end

    // Monitor: rebuilds frames and samples from the pins and pops the scoreboard.
    initial begin
        logic        ncs_prev;
        logic        done_prev;
        int          gap_cnt;
        int          since_fall;
        logic [63:0] cap;
        frame_t      f;
        ncs_prev   = 1'b1;
        done_prev  = 1'b0;
        gap_cnt    = 100;
        since_fall = 0;
        cap        = 64'h0;
        forever begin
            @(negedge clk);
            if (ncs_prev === 1'b1 && ncs_o === 1'b0) begin
                tests++;
                if (gap_cnt < CS_GAP) begin
                    fails++;
                    $display("FAIL cs_gap: got %0d cycles required >= %0d", gap_cnt, CS_GAP);
                end
                cur_len    = 0;
                since_fall = 0;
                cap        = 64'h0;
            end else if (ncs_o === 1'b0) begin
                since_fall++;
            end
            if (spi_start_o === 1'b1) begin
                if (cur_len == 0) check("ncs_lead", 64'(since_fall), 64'd1);
                else check("start_after_done", 64'(done_prev), 64'd1);
                if (cur_len < 8) cap[63-8*cur_len -: 8] = spi_data_o;
                cur_len++;
                n_starts++;
            end
            if (ncs_prev === 1'b0 && ncs_o === 1'b1) begin
                if (exp_frames.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL frame_unexpected: got %0h len %0d expected none", cap, cur_len);
                end else begin
                    f = exp_frames.pop_front();
                    check("frame_len", 64'(cur_len), 64'(f.len));
                    check("frame_bytes", cap, f.b);
                end
                frames_done++;
                gap_cnt = 0;
            end
            if (ncs_o === 1'b1) gap_cnt++;
            if (sample_valid_o === 1'b1) begin
                if (exp_samples.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sample_unexpected: got %0h expected none", {x_o, y_o, z_o});
                end else begin
                    check("sample_xyz", 64'({x_o, y_o, z_o}), 64'(exp_samples.pop_front()));
                end
            end
            done_prev = spi_done_i;
            ncs_prev  = ncs_o;
        end
    end

    task automatic push_bringup();
        push_frame(3, 64'h0B00000000000000);
        push_frame(3, 64'h0A2C130000000000);
        push_frame(3, 64'h0A2A010000000000);
        push_frame(3, 64'h0A2D020000000000);
    endtask

    initial begin
        int base;
        int t;
        int ns;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'hAD;
        mem[8'h0E] = 8'h34; mem[8'h0F] = 8'h12;
        mem[8'h10] = 8'hCD; mem[8'h11] = 8'hFB;
        mem[8'h12] = 8'h00; mem[8'h13] = 8'h04;

        rst_i = 1'b1;
        enable_i = 1'b0;
        int1_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ncs", 64'(ncs_o), 64'd1);
        check("rst_start", 64'(spi_start_o), 64'd0);
        check("rst_data", 64'(spi_data_o), 64'd0);
        check("rst_xyz", 64'({x_o, y_o, z_o}), 64'd0);
        check("rst_flags", 64'({sample_valid_o, ready_o, id_error_o}), 64'd0);
        rst_i = 1'b0;

        // Bring-up
        push_bringup();
        enable_i = 1'b1;
        for (t = 0; t < 1000 && ready_o !== 1'b1; t++) @(negedge clk);
        check("bringup_ready", 64'(ready_o), 64'd1);
        check("bringup_frames_left", 64'(exp_frames.size()), 64'd0);

        // Single sample
        push_frame(8, 64'h0B0E000000000000);
        exp_samples.push_back(48'h1234_FBCD_0400);
        pulse_int();
        for (t = 0; t < 500 && exp_samples.size() != 0; t++) @(negedge clk);
        check("sample_done", 64'(exp_samples.size()), 64'd0);
        repeat (10) @(negedge clk);
        check("sample_hold", 64'({x_o, y_o, z_o}), 64'h1234_FBCD_0400);
        check("sample_pulse_low", 64'(sample_valid_o), 64'd0);

        // Three edges during one read coalesce into one further read
        base = frames_done;
        push_frame(8, 64'h0B0E000000000000);
        push_frame(8, 64'h0B0E000000000000);
        exp_samples.push_back(48'h1234_FBCD_0400);
        exp_samples.push_back(48'h1234_FBCD_0400);
        pulse_int();
        for (t = 0; t < 200 && ncs_o !== 1'b0; t++) @(negedge clk);
        repeat (3) pulse_int();
        repeat (300) @(negedge clk);
        check("coalesce_frames", 64'(frames_done - base), 64'd2);
        check("coalesce_samples_left", 64'(exp_samples.size()), 64'd0);

        // Disable at byte 4 of a read
        mem[8'h0E] = 8'h01; mem[8'h0F] = 8'h02;
        mem[8'h10] = 8'h03; mem[8'h11] = 8'h04;
        mem[8'h12] = 8'h05; mem[8'h13] = 8'h06;
        base = frames_done;
        push_frame(8, 64'h0B0E000000000000);
        exp_samples.push_back(48'h0201_0403_0605);
        pulse_int();
        for (t = 0; t < 300 && !(ncs_o === 1'b0 && cur_len == 4); t++) begin
            @(negedge clk);
            #1;
        end
        enable_i = 1'b0;
        for (t = 0; t < 300 && exp_samples.size() != 0; t++) @(negedge clk);
        repeat (20) @(negedge clk);
        check("disable_samples_left", 64'(exp_samples.size()), 64'd0);
        check("disable_frames", 64'(frames_done - base), 64'd1);
        check("disable_ready", 64'(ready_o), 64'd0);
        check("disable_ncs", 64'(ncs_o), 64'd1);
        check("disable_hold_xyz", 64'({x_o, y_o, z_o}), 64'h0201_0403_0605);

        // Reset at byte 2 of CFG_INT
        base = frames_done;
        push_frame(3, 64'h0B00000000000000);
        push_frame(3, 64'h0A2C130000000000);
        push_frame(2, 64'h0A2A000000000000);
        enable_i = 1'b1;
        for (t = 0; t < 1000 && !(frames_done == base + 2 && ncs_o === 1'b0 && cur_len == 2); t++) begin
            @(negedge clk);
            #1;
        end
        rst_i = 1'b1;
        enable_i = 1'b0;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        @(negedge clk);
        check("midrst_ncs", 64'(ncs_o), 64'd1);
        check("midrst_start", 64'(spi_start_o), 64'd0);
        check("midrst_xyz", 64'({x_o, y_o, z_o}), 64'd0);
        check("midrst_flags", 64'({sample_valid_o, ready_o, id_error_o}), 64'd0);
        ns = n_starts;
        repeat (20) @(negedge clk);
        check("midrst_stray_done", 64'(n_starts - ns), 64'd0);
        check("midrst_ncs_hold", 64'(ncs_o), 64'd1);
        check("midrst_frames_left", 64'(exp_frames.size()), 64'd0);

        // DEVID mismatch
        mem[8'h00] = 8'h00;
        push_frame(3, 64'h0B00000000000000);
        enable_i = 1'b1;
        for (t = 0; t < 200 && id_error_o !== 1'b1; t++) @(negedge clk);
        check("iderr_flag", 64'(id_error_o), 64'd1);
        ns = n_starts;
        repeat (50) @(negedge clk);
        check("iderr_no_start", 64'(n_starts - ns), 64'd0);
        check("iderr_ncs", 64'(ncs_o), 64'd1);
        check("iderr_ready", 64'(ready_o), 64'd0);
        enable_i = 1'b0;
        repeat (3) @(negedge clk);
        check("iderr_clear", 64'(id_error_o), 64'd0);
        check("final_frames_left", 64'(exp_frames.size()), 64'd0);
        check("final_samples_left", 64'(exp_samples.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
